// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM encoding and lane slicing for the FIR MAC datapath
package fir_pkg;
    localparam int SAMPLE_W   = 18;
    localparam int COEF_W     = 18;
    localparam int LANES      = 4;
    localparam int WORD_W     = SAMPLE_W * LANES;
    localparam int RAM_ADDR_W = 12;
    localparam int ACCW_DEF   = 48;
    localparam int PROD_W     = SAMPLE_W + COEF_W;
    localparam int SUM_W      = PROD_W + 2;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    function automatic logic signed [SAMPLE_W-1:0] lane(input logic [WORD_W-1:0] w, input int i);
        return w[SAMPLE_W*i +: SAMPLE_W];
    endfunction
endpackage

// File: rtl/mac4_lane_sum.sv
// mac4_lane_sum: 4 lane-wise signed products summed into one word, 2-cycle latency
// Ports: clock/reset; x_word/h_word packed 4x18 operands with in_valid/in_first/in_last tags;
//        sum is the 38-bit signed lane total, tags delayed to match as out_valid/out_first/out_last.
module mac4_lane_sum
    import fir_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [WORD_W-1:0]       x_word,
    input  logic [WORD_W-1:0]       h_word,
    output logic                    out_valid,
    output logic                    out_first,
    output logic                    out_last,
    output logic signed [SUM_W-1:0] sum
);
    logic signed [PROD_W-1:0] prod [LANES];
    logic [2:0] tag;
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) prod[i] <= '0;
            tag <= '0;
            sum <= '0;
            {out_valid, out_first, out_last} <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) prod[i] <= lane(x_word, i) * lane(h_word, i);
            tag <= {in_valid, in_first, in_last};
            sum <= SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]) + SUM_W'(prod[3]);
            {out_valid, out_first, out_last} <= tag;
        end
    end
endmodule

// File: rtl/fir_mac4_engine.sv
// fir_mac4_engine: per-start 4-tap-per-cycle FIR MAC over N blocks with round/saturate output
// Ports: clock/reset; start pulse with nblk (N-1) latched on accept; ram_addr/coef_addr read
//        addresses with ram_dout/coef_data one cycle later; busy during a run; yout/sat held
//        result with one-cycle out_valid; overrun pulses when start arrives while busy.
module fir_mac4_engine
    import fir_pkg::*;
#(
    parameter int ACCW      = ACCW_DEF,
    parameter int OUT_SHIFT = 17
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [RAM_ADDR_W-1:0]        nblk,
    output logic [RAM_ADDR_W-1:0]        ram_addr,
    input  logic [WORD_W-1:0]            ram_dout,
    output logic [RAM_ADDR_W-1:0]        coef_addr,
    input  logic [WORD_W-1:0]            coef_data,
    output logic                         busy,
    output logic signed [SAMPLE_W-1:0]   yout,
    output logic                         out_valid,
    output logic                         sat,
    output logic                         overrun
);
    localparam logic signed [ACCW:0] HALF = (ACCW+1)'(1) <<< (OUT_SHIFT - 1);
    localparam logic signed [ACCW:0] YMAX = (ACCW+1)'(131071);
    localparam logic signed [ACCW:0] YMIN = (ACCW+1)'(-131072);
    state_t state;
    logic [RAM_ADDR_W-1:0] cnt, nlat;
    logic v1, f1, l1, v2, f2, l2, v4, f4, l4, done;
    logic [WORD_W-1:0] x_q, h_q;
    logic signed [SUM_W-1:0] sum;
    logic signed [ACCW-1:0] acc, sum_x;
    logic signed [ACCW:0] rnd, shf;
    logic hi, lo;
    logic signed [SAMPLE_W-1:0] y_sat;
    assign ram_addr  = cnt;
    assign coef_addr = cnt;
    assign sum_x     = ACCW'(sum);
    always_comb begin
        rnd   = {acc[ACCW-1], acc} + HALF;
        shf   = rnd >>> OUT_SHIFT;
        hi    = shf > YMAX;
        lo    = shf < YMIN;
        y_sat = hi ? 18'sh1ffff : lo ? 18'sh20000 : shf[SAMPLE_W-1:0];
    end
    // Data register stage: operands arrive one cycle after the address and are registered
    // before the multipliers, so the tag chain v1->v2 tracks that extra cycle.
    mac4_lane_sum u_sum (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (v2),
        .in_first  (f2),
        .in_last   (l2),
        .x_word    (x_q),
        .h_word    (h_q),
        .out_valid (v4),
        .out_first (f4),
        .out_last  (l4),
        .sum       (sum)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            nlat <= '0;
            busy <= 1'b0;
            {v1, f1, l1, v2, f2, l2} <= '0;
            x_q <= '0;
            h_q <= '0;
            acc <= '0;
            done <= 1'b0;
            yout <= '0;
            sat <= 1'b0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= start && state != IDLE;
            {v1, f1, l1} <= {state == RUN, cnt == '0, cnt == nlat};
            {v2, f2, l2} <= {v1, f1, l1};
            x_q <= ram_dout;
            h_q <= coef_data;
            // first block of a run loads, so back-to-back runs never see stale sums
            if (v4) acc <= f4 ? sum_x : acc + sum_x;
            done <= v4 && l4;
            out_valid <= done;
            if (done) begin
                yout <= y_sat;
                sat <= hi || lo;
            end
            if (state == IDLE && start) begin
                state <= RUN;
                cnt <= '0;
                nlat <= nblk;
                busy <= 1'b1;
            end else if (state == RUN) begin
                cnt <= cnt == nlat ? '0 : cnt + 1'b1;
                if (cnt == nlat) state <= DRAIN;
            end else if (state == DRAIN && done) begin
                state <= IDLE;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_mac4_engine.sv
// tb_fir_mac4_engine: randomized and directed checks of fir_mac4_engine against a convolution model
module tb_fir_mac4_engine;
    localparam int TAPS = 16384;
    logic clock = 1'b0;
    logic reset, start;
    logic [11:0] nblk, ram_addr, coef_addr;
    logic [71:0] ram_dout, coef_data;
    logic busy, out_valid, sat, overrun;
    logic signed [17:0] yout;
    logic signed [17:0] xs [TAPS];
    logic signed [17:0] hs [TAPS];
    int checks = 0;
    int failures = 0;

    fir_mac4_engine dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .nblk      (nblk),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .yout      (yout),
        .out_valid (out_valid),
        .sat       (sat),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    // xs[k] = x[n-k]; block j lane i holds tap 4j+3-i for both samples and coefficients
    function automatic logic [71:0] xword(input logic [11:0] a);
        logic [71:0] w;
        for (int i = 0; i < 4; i++) w[18*i +: 18] = xs[4*int'(a) + 3 - i];
        return w;
    endfunction

    function automatic logic [71:0] hword(input logic [11:0] a);
        logic [71:0] w;
        for (int i = 0; i < 4; i++) w[18*i +: 18] = hs[4*int'(a) + 3 - i];
        return w;
    endfunction

    always @(posedge clock) begin
        ram_dout  <= xword(ram_addr);
        coef_data <= hword(coef_addr);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_out(input int nb, output longint y, output bit s);
        longint acc, r;
        acc = 0;
        for (int k = 0; k < 4 * (nb + 1); k++) acc += longint'(xs[k]) * longint'(hs[k]);
        r = (acc + 65536) >>> 17;
        s = r > 131071 || r < -131072;
        y = r > 131071 ? 131071 : r < -131072 ? -131072 : r;
    endtask

    task automatic fill(input int n, input bit rnd, input int xv, input int hv);
        for (int k = 0; k < TAPS; k++) begin
            xs[k] = k >= n ? 18'sd0 : rnd ? 18'($urandom_range(0, 262143)) : 18'(xv);
            hs[k] = k >= n ? 18'sd0 : rnd ? 18'($urandom_range(0, 262143)) : 18'(hv);
        end
    endtask

    task automatic launch(input int nb);
        nblk = 12'(nb);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic track(input int nb, input int ovr_at, input string tag);
        int cyc, aerr, berr;
        longint y;
        bit s;
        cyc = 0;
        aerr = 0;
        berr = 0;
        while (1) begin
            if (cyc <= nb && int'(ram_addr) != cyc) aerr++;
            if (cyc <= nb + 4 && !busy) berr++;
            if (out_valid || cyc > nb + 40) break;
            if (ovr_at >= 0 && cyc == ovr_at) begin
                start = 1'b1;
                nblk = 12'(~nb);
            end
            if (ovr_at >= 0 && cyc == ovr_at + 1) begin
                start = 1'b0;
                check({tag, "_ovr_pulse"}, longint'(overrun), 1);
            end
            if (ovr_at >= 0 && cyc == ovr_at + 2) check({tag, "_ovr_clear"}, longint'(overrun), 0);
            @(posedge clock);
            #1;
            cyc++;
        end
        model_out(nb, y, s);
        check({tag, "_latency"}, cyc, nb + 6);
        check({tag, "_addr_seq"}, aerr, 0);
        check({tag, "_busy_run"}, berr, 0);
        check({tag, "_busy_end"}, longint'(busy), 0);
        check({tag, "_yout"}, longint'(yout), y);
        check({tag, "_sat"}, longint'(sat), longint'(s));
    endtask

    initial begin
        int seen, nb;
        reset = 1'b1;
        start = 1'b0;
        nblk = '0;
        fill(0, 1'b0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_addr", longint'(ram_addr), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_yout", longint'(yout), 0);
        check("rst_ov", longint'(out_valid), 0);
        check("rst_sat", longint'(sat), 0);
        check("rst_overrun", longint'(overrun), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        fill(0, 1'b0, 0, 0);
        xs[0] = 18'sd1000;
        hs[0] = 18'sd65536;
        launch(0);
        track(0, -1, "imp");
        check("imp_val", longint'(yout), 500);
        @(posedge clock);
        #1;
        check("imp_pulse_end", longint'(out_valid), 0);

        xs[0] = 18'sd3;
        launch(0);
        track(0, -1, "rnd_pos");
        check("rnd_pos_val", longint'(yout), 2);
        @(posedge clock);
        #1;
        xs[0] = -18'sd3;
        launch(0);
        track(0, -1, "rnd_neg");
        check("rnd_neg_val", longint'(yout), -1);
        @(posedge clock);
        #1;

        fill(16, 1'b0, 131071, 131071);
        launch(3);
        track(3, -1, "sat_pos");
        check("sat_pos_val", longint'(yout), 131071);
        check("sat_pos_flag", longint'(sat), 1);
        @(posedge clock);
        #1;
        fill(16, 1'b0, -131072, 131071);
        launch(3);
        track(3, -1, "sat_neg");
        check("sat_neg_val", longint'(yout), -131072);
        @(posedge clock);
        #1;

        fill(32, 1'b1, 0, 0);
        launch(7);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_busy", longint'(busy), 0);
        check("abort_yout", longint'(yout), 0);
        check("abort_sat", longint'(sat), 0);
        seen = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_ov", seen, 0);
        fill(0, 1'b0, 0, 0);
        xs[0] = 18'sd1000;
        hs[0] = 18'sd65536;
        launch(0);
        track(0, -1, "imp2");
        @(posedge clock);
        #1;

        fill(32, 1'b1, 0, 0);
        launch(7);
        track(7, 1, "ovr");
        @(posedge clock);
        #1;

        fill(24, 1'b1, 0, 0);
        launch(5);
        track(5, -1, "b2b_a");
        fill(12, 1'b1, 0, 0);
        launch(2);
        track(2, -1, "b2b_b");
        @(posedge clock);
        #1;

        repeat (6) begin
            nb = int'($urandom_range(0, 15));
            fill(4 * (nb + 1), 1'b1, 0, 0);
            launch(nb);
            track(nb, -1, "rand");
            @(posedge clock);
            #1;
        end

        fill(TAPS, 1'b0, 16384, 8);
        launch(4095);
        track(4095, -1, "full");
        check("full_val", longint'(yout), 16384);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
